// File: rtl/seq_gen_ctrl.sv
// ---------------------------------------------------------------------------
// SeqGenCtrl : serial test-pattern player for the 5-state sequence detector
//
// Purpose
//   Latches a parallel pattern, shifts it out MSB-first at BIT_DIV clocks per
//   bit, and counts rising edges of the detector's seq_jug flag. A
//   start/busy/done handshake reports completion. In loop mode the pattern is
//   reloaded at each pass end with no gap in the bit stream.
//
// Parameters
//   SEQ_LEN  pattern length in bits (2..32)
//   BIT_DIV  clk cycles per serial bit (>= 1)
//   CNT_W    hit counter width (saturating)
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   run request, honoured only in IDLE
//   stop      in   abort request, honoured in SHIFT and IDLE (wins over start)
//   loop_en   in   repeat the pattern, sampled at each pattern end
//   pattern   in   [SEQ_LEN] pattern, latched at start and at each reload
//   seq_jug   in   detector hit flag
//   seq_bit   out  serial bit to the detector
//   bit_stb   out  pulse on the first cycle of each new bit
//   busy      out  high while shifting
//   done      out  one-cycle pulse on normal completion
//   hit_cnt   out  [CNT_W] hits in the current/last run
//   state     out  [2] IDLE=00, SHIFT=01, DONE=10
//
// Optional feature
//   SEQ_GEN_CTRL_HIT_STOP_EN : when defined, the first hit seen while
//   shifting ends the run (DONE next cycle), even in loop mode.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module seq_gen_ctrl #(
  parameter int SEQ_LEN = 16,
  parameter int BIT_DIV = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [SEQ_LEN-1:0] pattern,
  input  logic               seq_jug,
  output logic               seq_bit,
  output logic               bit_stb,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [1:0]         state
);

  localparam int DIV_W = $clog2(BIT_DIV + 1);
  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0] HIT_MAX  = {CNT_W{1'b1}};

`ifdef SEQ_GEN_CTRL_HIT_STOP_EN
  localparam bit HIT_STOP_EN = 1'b1;
`else
  localparam bit HIT_STOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [SEQ_LEN-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic               seqBit_q, seqBit_d;
  logic               bitStb_q, bitStb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               jug_q;

  logic               hit;
  logic               countEn;
  logic               bitLast;
  logic               patLast;

  // A hit is a rising edge of seq_jug. Counting also runs in DONE so a hit
  // caused by the last bit (detector output lags one cycle) is not lost.
  always_comb begin
    hit     = seq_jug & ~jug_q;
    countEn = hit && (state_q == SHIFT || state_q == DONE) && (hit_q != HIT_MAX);
    bitLast = (div_q == DIV_LAST);
    patLast = (idx_q == IDX_LAST);
  end

  // Next-state and registered-output logic. Each output's next value is
  // computed here so that the flop holds exactly what the current cycle must
  // show; the bit that follows a shift is therefore sr_q[SEQ_LEN-2].
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    idx_d    = idx_q;
    div_d    = div_q;
    hit_d    = countEn ? hit_q + CNT_W'(1) : hit_q;
    seqBit_d = 1'b0;
    bitStb_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d  = SHIFT;
          sr_d     = pattern;
          idx_d    = '0;
          div_d    = '0;
          hit_d    = '0;
          seqBit_d = pattern[SEQ_LEN-1];
          bitStb_d = 1'b1;
          busy_d   = 1'b1;
        end
      end

      SHIFT: begin
        if (stop) begin
          state_d = IDLE;
        end else if (HIT_STOP_EN && hit) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (!bitLast) begin
          div_d    = div_q + DIV_W'(1);
          seqBit_d = sr_q[SEQ_LEN-1];
          busy_d   = 1'b1;
        end else if (!patLast) begin
          div_d    = '0;
          sr_d     = {sr_q[SEQ_LEN-2:0], 1'b0};
          idx_d    = idx_q + IDX_W'(1);
          seqBit_d = sr_q[SEQ_LEN-2];
          bitStb_d = 1'b1;
          busy_d   = 1'b1;
        end else if (loop_en) begin
          // Reload in place so the next pass starts without a gap cycle.
          div_d    = '0;
          sr_d     = pattern;
          idx_d    = '0;
          seqBit_d = pattern[SEQ_LEN-1];
          bitStb_d = 1'b1;
          busy_d   = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      idx_q    <= '0;
      div_q    <= '0;
      hit_q    <= '0;
      seqBit_q <= 1'b0;
      bitStb_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      div_q    <= div_d;
      hit_q    <= hit_d;
      seqBit_q <= seqBit_d;
      bitStb_q <= bitStb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Edge-detect history of seq_jug, tracked in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jug_q <= 1'b0;
    end else begin
      jug_q <= seq_jug;
    end
  end

  assign seq_bit = seqBit_q;
  assign bit_stb = bitStb_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign hit_cnt = hit_q;
  assign state   = state_q;

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// ---------------------------------------------------------------------------
// TbSeqGenCtrl : directed self-checking bench for seq_gen_ctrl
//
// Two instances share the pattern, seq_jug and reset: dut (BIT_DIV=1) and
// dut4 (BIT_DIV=4), each with its own start. The detector is replaced by
// directly driven seq_jug pulses so every hit count is known by hand.
// Outputs are sampled 1 ns after the rising edge; inputs are changed at the
// same point, so they are stable well before the next edge.
// ---------------------------------------------------------------------------
module tb_seq_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start4, stop, loop_en, seq_jug;
  logic [15:0] pattern;

  logic        seq_bit, bit_stb, busy, done;
  logic [7:0]  hit_cnt;
  logic [1:0]  state;

  logic        seq_bit4, bit_stb4, busy4, done4;
  logic [7:0]  hit_cnt4;
  logic [1:0]  state4;

  logic [15:0] expPat;
  int          checks = 0;
  int          errors = 0;
  int          stbCount;

  always #5 clk = ~clk;

  seq_gen_ctrl #(.SEQ_LEN(16), .BIT_DIV(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .pattern(pattern), .seq_jug(seq_jug), .seq_bit(seq_bit), .bit_stb(bit_stb),
    .busy(busy), .done(done), .hit_cnt(hit_cnt), .state(state)
  );

  seq_gen_ctrl #(.SEQ_LEN(16), .BIT_DIV(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop), .loop_en(loop_en),
    .pattern(pattern), .seq_jug(seq_jug), .seq_bit(seq_bit4), .bit_stb(bit_stb4),
    .busy(busy4), .done(done4), .hit_cnt(hit_cnt4), .state(state4)
  );

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives the control inputs of the BIT_DIV=1 instance in one go.
  task automatic applyStimulus(input logic s, input logic p, input logic l,
                               input logic j);
    start   = s;
    stop    = p;
    loop_en = l;
    seq_jug = j;
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence of test steps.
  initial begin
    rst_n   = 1'b0;
    start4  = 1'b0;
    pattern = 16'h0000;
    expPat  = 16'h0D95;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // ---- reset values ----
    tick();
    tick();
    checkOutput("rst_state", state, 2'b00);
    checkOutput("rst_seq_bit", seq_bit, 1'b0);
    checkOutput("rst_bit_stb", bit_stb, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_hit_cnt", hit_cnt, 8'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("idle_after_rst", state, 2'b00);

    // ---- normal run, 0x0D95, start ignored mid-run, hit in DONE ----
    pattern = 16'h0D95;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checkOutput("run_state", state, 2'b01);
      checkOutput("run_busy", busy, 1'b1);
      checkOutput("run_bit", seq_bit, expPat[15-k]);
      checkOutput("run_stb", bit_stb, 1'b1);
      checkOutput("run_done", done, 1'b0);
      start = (k == 3);
      tick();
    end
    checkOutput("done_state", state, 2'b10);
    checkOutput("done_pulse", done, 1'b1);
    checkOutput("done_busy", busy, 1'b0);
    checkOutput("done_seq_bit", seq_bit, 1'b0);
    checkOutput("done_hit_before", hit_cnt, 8'd0);
    seq_jug = 1'b1;
    tick();
    seq_jug = 1'b0;
    checkOutput("post_state", state, 2'b00);
    checkOutput("post_done", done, 1'b0);
    checkOutput("post_hit_in_done", hit_cnt, 8'd1);

    // ---- mid-SHIFT asynchronous reset ----
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    repeat (5) tick();
    checkOutput("prereset_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_state", state, 2'b00);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_seq_bit", seq_bit, 1'b0);
    checkOutput("arst_bit_stb", bit_stb, 1'b0);
    checkOutput("arst_done", done, 1'b0);
    checkOutput("arst_hit_cnt", hit_cnt, 8'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("arst_stay_idle", state, 2'b00);
    checkOutput("arst_stay_busy", busy, 1'b0);

    // ---- start and stop together in IDLE ----
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("startstop_state", state, 2'b00);
    checkOutput("startstop_busy", busy, 1'b0);
    tick();
    checkOutput("startstop_state2", state, 2'b00);

    // ---- loop mode: two passes, one hit per pass, then stop ----
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      checkOutput("loop_state", state, 2'b01);
      checkOutput("loop_busy", busy, 1'b1);
      checkOutput("loop_done", done, 1'b0);
      checkOutput("loop_bit", seq_bit, expPat[15-(k%16)]);
      checkOutput("loop_stb", bit_stb, 1'b1);
      seq_jug = (k == 5) || (k == 21);
      stop    = (k == 31);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("loopstop_state", state, 2'b00);
    checkOutput("loopstop_busy", busy, 1'b0);
    checkOutput("loopstop_done", done, 1'b0);
    checkOutput("loopstop_seq_bit", seq_bit, 1'b0);
    checkOutput("loopstop_hit_cnt", hit_cnt, 8'd2);

    // ---- abort after 5 bits, hit count held ----
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("abort_bit", seq_bit, expPat[15-k]);
      seq_jug = (k == 1);
      stop    = (k == 4);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_state", state, 2'b00);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_seq_bit", seq_bit, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_hit_cnt", hit_cnt, 8'd1);
    repeat (2) tick();
    checkOutput("abort_hold_hit", hit_cnt, 8'd1);
    checkOutput("abort_hold_state", state, 2'b00);

    // ---- seq_jug held high for 20 cycles counts once ----
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    start   = 1'b0;
    seq_jug = 1'b1;
    repeat (17) tick();
    checkOutput("level_state", state, 2'b00);
    checkOutput("level_hit_cnt", hit_cnt, 8'd1);
    repeat (3) tick();
    seq_jug = 1'b0;
    tick();
    checkOutput("level_hit_after", hit_cnt, 8'd1);

    // ---- 300 hits saturate at 255 ----
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 600; i++) begin
      seq_jug = ~seq_jug;
      tick();
    end
    checkOutput("sat_busy", busy, 1'b1);
    checkOutput("sat_hit_cnt", hit_cnt, 8'd255);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    stop = 1'b0;
    checkOutput("sat_stop_state", state, 2'b00);
    checkOutput("sat_stop_hit", hit_cnt, 8'd255);

    // ---- BIT_DIV=4 instance, pattern 0xFFFF ----
    pattern  = 16'hFFFF;
    start4   = 1'b1;
    stbCount = 0;
    tick();
    start4 = 1'b0;
    for (int c = 0; c < 64; c++) begin
      checkOutput("div4_state", state4, 2'b01);
      checkOutput("div4_busy", busy4, 1'b1);
      checkOutput("div4_bit", seq_bit4, 1'b1);
      checkOutput("div4_stb", bit_stb4, (c % 4) == 0);
      if (bit_stb4) stbCount++;
      tick();
    end
    checkOutput("div4_stb_count", stbCount, 16);
    checkOutput("div4_done", done4, 1'b1);
    checkOutput("div4_done_state", state4, 2'b10);
    checkOutput("div4_done_busy", busy4, 1'b0);
    tick();
    checkOutput("div4_idle", state4, 2'b00);
    checkOutput("div4_done_clr", done4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
